// File: rtl/lzc_pkg.sv
// Shared definitions for the leading-zero-count stimulus generator.
// Holds the generator state encoding, the LFSR polynomial and default seed,
// and helpers to step the LFSR and to build one data beat of a frame.
package lzc_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SEND, WAIT} state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 expressed as state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Widest beat the beat builder can produce
  localparam int MAX_WIDTH = 16;

  // One Fibonacci step: shift left, XOR of the tapped bits enters at bit 0
  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Builds beat k of a frame whose leading run of polarity r is n bits long.
  // Frame bit b = k*width + j counts from the beat MSB (j = 0). Bits before
  // the run end copy r, the terminating bit is ~r, and every later bit takes
  // the LFSR bit sitting at the same position in the beat.
  function automatic logic [MAX_WIDTH-1:0] buildBeat(input int width, input int n,
                                                     input logic r, input int k,
                                                     input logic [15:0] lfsr);
    logic [MAX_WIDTH-1:0] beat;
    int                   b;
    beat = '0;
    for (int p = 0; p < MAX_WIDTH; p++) begin
      if (p < width) begin
        b = k * width + (width - 1 - p);
        if (b < n)       beat[p] = r;
        else if (b == n) beat[p] = ~r;
        else             beat[p] = lfsr[p];
      end
    end
    return beat;
  endfunction

endpackage

// File: rtl/lzc_lfsr16.sv
// 16-bit Fibonacci LFSR used as the random fill source for stimulus frames.
// Ports:
//   i_clk     - clock, rising edge
//   i_load    - load SEED (takes priority over i_advance)
//   i_advance - step the register once
//   o_state   - current 16-bit LFSR value
module lzc_lfsr16
  import lzc_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_load,
  input  logic        i_advance,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // Loading wins so that a reset arriving mid-frame always restarts the
  // random sequence from the seed, regardless of any pending advance.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_state <= SEED;
    end else if (i_advance) begin
      r_state <= lfsrStep(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lzc_stim_gen.sv
// Stimulus generator and result checker for the leading-zero-count engine.
// Accepts a requested run length, emits a WORD-beat frame whose leading run
// has that length, then checks the count the engine returns.
// Ports:
//   CLK, RST            - clock and synchronous active-high reset
//   REQ_VALID/REQ_READY - request handshake; REQ_ZEROS run length, REQ_MODE polarity
//   DATA_VALID, DATA    - beats toward the engine, most-significant beat first
//   MODE                - frame polarity, stable for the whole frame
//   ZEROS_VALID/ZEROS_IN- engine result strobe and count
//   RES_PASS/RES_FAIL/RES_TIMEOUT - one-cycle verdict pulses
//   PASS_CNT/FAIL_CNT   - saturating verdict counters (timeouts count as fails)
module lzc_stim_gen
  import lzc_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          WORD    = 4,
  parameter int          ZW      = 6,
  parameter logic [15:0] SEED    = DEFAULT_SEED,
  parameter int          TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [ZW-1:0]    REQ_ZEROS,
  input  logic             REQ_MODE,
  output logic             DATA_VALID,
  output logic [WIDTH-1:0] DATA,
  output logic             MODE,
  input  logic             ZEROS_VALID,
  input  logic [ZW-1:0]    ZEROS_IN,
  output logic             RES_PASS,
  output logic             RES_FAIL,
  output logic             RES_TIMEOUT,
  output logic [15:0]      PASS_CNT,
  output logic [15:0]      FAIL_CNT
);

  localparam int            BW      = $clog2(WORD + 1);
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [ZW-1:0] FRAME_N = ZW'(WIDTH * WORD);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_reqReady;
  logic [ZW-1:0]    r_n;
  logic             r_mode;
  logic [BW-1:0]    r_beat;
  logic [TW-1:0]    r_wait;
  logic             r_dataValid;
  logic [WIDTH-1:0] r_data;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [15:0]      r_passCnt;
  logic [15:0]      r_failCnt;

  logic             w_accept;
  logic [ZW-1:0]    w_clampN;
  logic             w_lastBeat;
  logic             w_timeoutHit;
  logic             w_loadBeat;
  logic             w_resPass;
  logic             w_resFail;
  logic             w_resTimeout;
  logic [WIDTH-1:0] w_beat;
  logic [15:0]      w_lfsr;

  lzc_lfsr16 #(.SEED(SEED)) uLfsr (
    .i_clk    (CLK),
    .i_load   (RST),
    .i_advance(w_loadBeat),
    .o_state  (w_lfsr)
  );

  // REQ_READY is a register, so the accept qualifier also keeps the cycle
  // straight after reset from taking a request before READY is visible.
  assign w_accept     = (r_state == IDLE) && r_reqReady && REQ_VALID;
  assign w_clampN     = (REQ_ZEROS > FRAME_N) ? FRAME_N : REQ_ZEROS;
  assign w_lastBeat   = (r_beat == BW'(WORD));
  assign w_timeoutHit = (r_wait == TW'(TIMEOUT - 1));

  // State register: the only place the FSM state is updated.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. In WAIT the strobe is tested before the timeout so a
  // result arriving on the final wait cycle still gets compared.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SETUP;
      SETUP:   w_nextState = SEND;
      SEND:    if (w_lastBeat) w_nextState = WAIT;
      WAIT:    if (ZEROS_VALID || w_timeoutHit) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode. Every output is registered, so these are the values the
  // output registers take at the coming edge; a beat is loaded whenever the
  // FSM is heading into (or staying in) SEND, and that is also when the LFSR
  // steps, so each beat sees the LFSR value before its own advance.
  always_comb begin
    w_loadBeat   = (w_nextState == SEND);
    w_resPass    = (r_state == WAIT) && ZEROS_VALID && (ZEROS_IN == r_n);
    w_resFail    = (r_state == WAIT) && ZEROS_VALID && (ZEROS_IN != r_n);
    w_resTimeout = (r_state == WAIT) && !ZEROS_VALID && w_timeoutHit;
    w_beat       = WIDTH'(buildBeat(WIDTH, int'(r_n), r_mode, int'(r_beat), w_lfsr));
  end

  // Datapath and output registers: latched request, beat/wait counters,
  // registered stream outputs, verdict pulses and saturating counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_reqReady  <= 1'b0;
      r_n         <= '0;
      r_mode      <= 1'b0;
      r_beat      <= '0;
      r_wait      <= '0;
      r_dataValid <= 1'b0;
      r_data      <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_passCnt   <= '0;
      r_failCnt   <= '0;
    end else begin
      r_reqReady  <= (w_nextState == IDLE);
      r_dataValid <= w_loadBeat;
      r_data      <= w_loadBeat ? w_beat : '0;
      r_pass      <= w_resPass;
      r_fail      <= w_resFail;
      r_timeout   <= w_resTimeout;
      r_wait      <= (r_state == WAIT) ? r_wait + TW'(1) : '0;
      if (w_accept) begin
        r_n    <= w_clampN;
        r_mode <= REQ_MODE;
        r_beat <= '0;
      end else if (w_loadBeat) begin
        r_beat <= r_beat + BW'(1);
      end
      if (w_resPass && (r_passCnt != 16'hFFFF)) begin
        r_passCnt <= r_passCnt + 16'd1;
      end
      if ((w_resFail || w_resTimeout) && (r_failCnt != 16'hFFFF)) begin
        r_failCnt <= r_failCnt + 16'd1;
      end
    end
  end

  assign REQ_READY   = r_reqReady;
  assign DATA_VALID  = r_dataValid;
  assign DATA        = r_data;
  assign MODE        = r_mode;
  assign RES_PASS    = r_pass;
  assign RES_FAIL    = r_fail;
  assign RES_TIMEOUT = r_timeout;
  assign PASS_CNT    = r_passCnt;
  assign FAIL_CNT    = r_failCnt;

endmodule

// File: tb/tb_lzc_stim_gen.sv
// Self-checking bench for lzc_stim_gen (WIDTH=8, WORD=4, SEED=16'hACE1,
// TIMEOUT=16). Expected beats and verdicts are queued when a request is
// issued; a negedge monitor checks every beat, the scenario tasks check
// verdicts, counters and handshake timing.
module tb_lzc_stim_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [5:0]  REQ_ZEROS = '0;
  logic        REQ_MODE = 1'b0;
  logic        DATA_VALID;
  logic [7:0]  DATA;
  logic        MODE;
  logic        ZEROS_VALID = 1'b0;
  logic [5:0]  ZEROS_IN = '0;
  logic        RES_PASS;
  logic        RES_FAIL;
  logic        RES_TIMEOUT;
  logic [15:0] PASS_CNT;
  logic [15:0] FAIL_CNT;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acceptCyc = 0;
  int          firstValidCyc = 0;
  int          beatsSeen = 0;
  logic [15:0] tbLfsr = SEED;
  logic        expMode = 1'b0;
  int          expPass = 0;
  int          expFail = 0;
  logic [7:0]  beatQ[$];
  logic [2:0]  resultQ[$];
  logic [7:0]  lastBeats[4];
  logic [7:0]  expBeat;

  lzc_stim_gen #(.WIDTH(8), .WORD(4), .ZW(6), .SEED(SEED), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ZEROS(REQ_ZEROS), .REQ_MODE(REQ_MODE),
    .DATA_VALID(DATA_VALID), .DATA(DATA), .MODE(MODE),
    .ZEROS_VALID(ZEROS_VALID), .ZEROS_IN(ZEROS_IN),
    .RES_PASS(RES_PASS), .RES_FAIL(RES_FAIL), .RES_TIMEOUT(RES_TIMEOUT),
    .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Beat monitor: every valid beat is popped from the scoreboard and compared,
  // and the frame polarity is checked on each beat.
  always @(negedge CLK) begin
    if (DATA_VALID) begin
      checks++;
      if (beatQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL beat_unexpected got=%h expected none", DATA);
      end else begin
        expBeat = beatQ.pop_front();
        if (DATA !== expBeat) begin
          errors++;
          $display("[TB] FAIL beat%0d got=%h expected=%h", beatsSeen, DATA, expBeat);
        end
      end
      checks++;
      if (MODE !== expMode) begin
        errors++;
        $display("[TB] FAIL mode_during_frame got=%b expected=%b", MODE, expMode);
      end
      if (beatsSeen == 0) firstValidCyc = cyc;
      if (beatsSeen < 4) lastBeats[beatsSeen] = DATA;
      beatsSeen++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] modelStep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Issues one request and queues the expected frame and verdict.
  // resp < 0 means no result will be returned (timeout expected).
  task automatic applyStimulus(input int reqZeros, input logic mode, input int resp);
    int          n;
    int          waitCnt;
    logic [31:0] frame;
    waitCnt = 0;
    while (REQ_READY !== 1'b1 && waitCnt < 40) begin
      tick();
      waitCnt++;
    end
    checks++;
    if (REQ_READY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_ready_wait got=%b expected=1", REQ_READY);
    end
    n = (reqZeros > 32) ? 32 : reqZeros;
    for (int k = 0; k < 4; k++) begin
      frame[31 - 8 * k -: 8] = tbLfsr[7:0];
      tbLfsr = modelStep(tbLfsr);
    end
    for (int b = 0; b < 32; b++) begin
      if (b < n)       frame[31 - b] = mode;
      else if (b == n) frame[31 - b] = ~mode;
    end
    for (int k = 0; k < 4; k++) beatQ.push_back(frame[31 - 8 * k -: 8]);
    if (resp < 0)       resultQ.push_back(3'b100);
    else if (resp == n) resultQ.push_back(3'b001);
    else                resultQ.push_back(3'b010);
    expMode   = mode;
    beatsSeen = 0;
    REQ_VALID = 1'b1;
    REQ_ZEROS = 6'(reqZeros);
    REQ_MODE  = mode;
    acceptCyc = cyc;
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic waitBeats(input int target);
    for (int i = 0; i < 20 && beatsSeen < target; i++) tick();
    checks++;
    if (beatsSeen != target) begin
      errors++;
      $display("[TB] FAIL beat_count got=%0d expected=%0d", beatsSeen, target);
    end
  endtask

  task automatic respond(input int value);
    ZEROS_VALID = 1'b1;
    ZEROS_IN    = 6'(value);
    tick();
    ZEROS_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({REQ_READY, DATA_VALID, MODE, RES_PASS, RES_FAIL, RES_TIMEOUT} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got=%b expected=000000",
               {REQ_READY, DATA_VALID, MODE, RES_PASS, RES_FAIL, RES_TIMEOUT});
    end
    checks++;
    if (DATA !== 8'h00 || PASS_CNT !== 16'd0 || FAIL_CNT !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_values got=%h/%h/%h expected=00/0000/0000", DATA, PASS_CNT, FAIL_CNT);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (REQ_READY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got=%b expected=1", REQ_READY);
    end
  endtask

  task automatic test_zero_run();
    logic [2:0] expR;
    applyStimulus(0, 1'b0, 0);
    waitBeats(4);
    tick();
    respond(0);
    expR = resultQ.pop_front();
    if (expR[0]) expPass++;
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== expR) begin
      errors++;
      $display("[TB] FAIL zero_run_verdict got=%b expected=%b", {RES_TIMEOUT, RES_FAIL, RES_PASS}, expR);
    end
    checks++;
    if (PASS_CNT !== 16'(expPass) || REQ_READY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_run_cnt got=%0d/%b expected=%0d/1", PASS_CNT, REQ_READY, expPass);
    end
    checks++;
    if (lastBeats[0][7] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_run_msb got=%b expected=1", lastBeats[0][7]);
    end
    tick();
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL pulse_width got=%b expected=000", {RES_TIMEOUT, RES_FAIL, RES_PASS});
    end
  endtask

  task automatic test_run11();
    logic [2:0] expR;
    applyStimulus(11, 1'b0, 11);
    waitBeats(4);
    checks++;
    if (firstValidCyc != acceptCyc + 2) begin
      errors++;
      $display("[TB] FAIL first_beat_latency got=%0d expected=%0d", firstValidCyc - acceptCyc, 2);
    end
    checks++;
    if (lastBeats[0] !== 8'h00 || lastBeats[1][7:4] !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL run11_beats got=%h/%h expected=00/1x", lastBeats[0], lastBeats[1]);
    end
    tick();
    checks++;
    if (DATA_VALID !== 1'b0 || beatsSeen != 4) begin
      errors++;
      $display("[TB] FAIL run11_valid_len got=%b/%0d expected=0/4", DATA_VALID, beatsSeen);
    end
    respond(11);
    expR = resultQ.pop_front();
    if (expR[0]) expPass++;
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== expR || PASS_CNT !== 16'(expPass)) begin
      errors++;
      $display("[TB] FAIL run11_verdict got=%b/%0d expected=%b/%0d",
               {RES_TIMEOUT, RES_FAIL, RES_PASS}, PASS_CNT, expR, expPass);
    end
  endtask

  task automatic test_clamp();
    logic [2:0] expR;
    applyStimulus(40, 1'b0, 32);
    waitBeats(4);
    checks++;
    if ({lastBeats[0], lastBeats[1], lastBeats[2], lastBeats[3]} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL clamp_frame got=%h%h%h%h expected=00000000",
               lastBeats[0], lastBeats[1], lastBeats[2], lastBeats[3]);
    end
    tick();
    respond(32);
    expR = resultQ.pop_front();
    if (expR[0]) expPass++;
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== expR || PASS_CNT !== 16'(expPass)) begin
      errors++;
      $display("[TB] FAIL clamp_verdict got=%b/%0d expected=%b/%0d",
               {RES_TIMEOUT, RES_FAIL, RES_PASS}, PASS_CNT, expR, expPass);
    end
  endtask

  task automatic test_mismatch();
    logic [2:0] expR;
    applyStimulus(3, 1'b1, 4);
    waitBeats(4);
    checks++;
    if (lastBeats[0][7:4] !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL ones_run_beat0 got=%b expected=1110", lastBeats[0][7:4]);
    end
    tick();
    respond(4);
    expR = resultQ.pop_front();
    if (expR[1]) expFail++;
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== expR || FAIL_CNT !== 16'(expFail)) begin
      errors++;
      $display("[TB] FAIL mismatch_verdict got=%b/%0d expected=%b/%0d",
               {RES_TIMEOUT, RES_FAIL, RES_PASS}, FAIL_CNT, expR, expFail);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] expR;
    logic       early;
    applyStimulus(5, 1'b0, -1);
    waitBeats(4);
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (RES_TIMEOUT !== 1'b0 || REQ_READY !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early got=1 expected=0");
    end
    tick();
    expR = resultQ.pop_front();
    if (expR[2]) expFail++;
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== expR || REQ_READY !== 1'b1 || FAIL_CNT !== 16'(expFail)) begin
      errors++;
      $display("[TB] FAIL timeout_verdict got=%b/%b/%0d expected=%b/1/%0d",
               {RES_TIMEOUT, RES_FAIL, RES_PASS}, REQ_READY, FAIL_CNT, expR, expFail);
    end
    tick();
    respond(5);
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== 3'b000 || PASS_CNT !== 16'(expPass) ||
        FAIL_CNT !== 16'(expFail) || REQ_READY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stray_strobe got=%b/%0d/%0d expected=000/%0d/%0d",
               {RES_TIMEOUT, RES_FAIL, RES_PASS}, PASS_CNT, FAIL_CNT, expPass, expFail);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] expR;
    applyStimulus(11, 1'b0, -1);
    waitBeats(3);
    RST = 1'b1;
    tick();
    checks++;
    if (DATA_VALID !== 1'b0 || PASS_CNT !== 16'd0 || FAIL_CNT !== 16'd0 || REQ_READY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got=%b/%0d/%0d/%b expected=0/0/0/0",
               DATA_VALID, PASS_CNT, FAIL_CNT, REQ_READY);
    end
    RST = 1'b0;
    beatQ.delete();
    resultQ.delete();
    tbLfsr  = SEED;
    expPass = 0;
    expFail = 0;
    tick();
    applyStimulus(11, 1'b0, 11);
    waitBeats(4);
    checks++;
    if (lastBeats[0] !== 8'h00 || lastBeats[1][7:4] !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reseed_beats got=%h/%h expected=00/1x", lastBeats[0], lastBeats[1]);
    end
    tick();
    respond(11);
    expR = resultQ.pop_front();
    if (expR[0]) expPass++;
    checks++;
    if ({RES_TIMEOUT, RES_FAIL, RES_PASS} !== expR || PASS_CNT !== 16'(expPass)) begin
      errors++;
      $display("[TB] FAIL reseed_verdict got=%b/%0d expected=%b/%0d",
               {RES_TIMEOUT, RES_FAIL, RES_PASS}, PASS_CNT, expR, expPass);
    end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_run11();
    test_clamp();
    test_mismatch();
    test_timeout();
    test_reset_mid_frame();
    tick();
    checks++;
    if (beatQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_beats got=%0d expected=0", beatQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
